// File: rtl/ad9643_axil_regs_pkg.sv
// Shared definitions for the AD9643 capture-path AXI4-Lite register file:
// register byte offsets, CTRL bit positions, response codes and channel states.
package ad9643_regs_pkg;

  localparam logic [3:0] OFF_CTRL      = 4'h0;
  localparam logic [3:0] OFF_FRAME_LEN = 4'h4;
  localparam logic [3:0] OFF_STATUS    = 4'h8;
  localparam logic [3:0] OFF_SCRATCH   = 4'hC;

  localparam int CTRL_CAPTURE_EN = 0;
  localparam int CTRL_SOFT_RST   = 1;
  localparam int CTRL_TEST_MODE  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/ad9643_axil_regs_if.sv
// AXI4-Lite bus bundle between the configuration master and the AD9643
// register file. Clock and reset travel separately as plain ports.
interface ad9643_axil_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/ad9643_axil_wr_ch.sv
// AXI4-Lite write channel: latches AW and W independently (either order or
// together), presents a single-cycle register write strobe on the edge where
// the second of the two is taken, then holds the B response until accepted.
module ad9643_axil_wr_ch
  import ad9643_regs_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock_axi,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [3:0]            wr_strb
);

  wr_state_t             state;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [3:0]            strb_q;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  aw_have;
  logic                  w_have;
  logic                  commit;
  logic                  addr_mapped;

  // Merge latched and same-cycle AW/W beats into the commit strobe.
  always_comb begin
    aw_fire     = awvalid && awready;
    w_fire      = wvalid && wready;
    aw_have     = aw_held || aw_fire;
    w_have      = w_held || w_fire;
    commit      = (state == WR_IDLE) && aw_have && w_have;
    wr_addr     = aw_held ? addr_q : awaddr;
    wr_data     = w_held ? data_q : wdata;
    wr_strb     = w_held ? strb_q : wstrb;
    addr_mapped = (wr_addr >> 4) == '0;
    wr_en       = commit && addr_mapped;
  end

  // Hold the address/data of whichever beat arrived first.
  always_ff @(posedge clock_axi) begin
    if (aw_fire) addr_q <= awaddr;
    if (w_fire) begin
      data_q <= wdata;
      strb_q <= wstrb;
    end
  end

  // Write FSM: ready flags are registered so they drop during reset and B.
  always_ff @(posedge clock_axi) begin
    if (!aresetn) begin
      state   <= WR_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (state)
        WR_IDLE: begin
          if (commit) begin
            state   <= WR_RESP;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= addr_mapped ? RESP_OKAY : RESP_SLVERR;
          end else begin
            aw_held <= aw_have;
            w_held  <= w_have;
            awready <= !aw_have;
            wready  <= !w_have;
          end
        end
        WR_RESP: begin
          if (bready) begin
            state   <= WR_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ad9643_axil_regs.sv
// AXI4-Lite register file configuring the AD9643 LVDS capture path:
// CTRL (capture enable, soft reset pulse, test mode), FRAME_LEN, STATUS
// (sticky overflow, frame counter) and SCRATCH.
// Build option: define AD9643_AXIL_WSTRB_EN to honour per-byte write
// strobes; otherwise every write replaces the whole word.
module ad9643_axil_regs
  import ad9643_regs_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 4,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [15:0] FRAME_LEN_RST = 16'd1024
) (
  input  logic         s_axi_aclk,
  input  logic         s_axi_aresetn,
  ad9643_axil_if.slave s_axi,
  output logic         capture_en,
  output logic         test_mode,
  output logic         soft_rst,
  output logic [15:0]  frame_len,
  input  logic         ovf_pulse,
  input  logic         frame_pulse
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("ad9643_axil_regs: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 4) begin : g_bad_addr_width
    $error("ad9643_axil_regs: ADDR_WIDTH must be at least 4");
  end

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [3:0]            wr_sel;
  logic [3:0]            rd_sel;
  logic [31:0]           ctrl_word;
  logic [31:0]           status_word;
  logic [31:0]           wr_old;
  logic [31:0]           wr_word;
  logic [31:0]           rd_word;
  logic                  soft_clr;
  logic                  ovf_w1c;
  logic                  rd_mapped;
  logic                  ovf;
  logic [15:0]           frame_cnt;
  logic [31:0]           scratch;
  rd_state_t             rd_state;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;

  // Protection bits and the byte lane of addresses carry no meaning here.
  wire unused_bits = ^{s_axi.awprot, s_axi.arprot, wr_addr};

  function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    logic        unused_args;
    unused_args = 1'b0;
`ifdef AD9643_AXIL_WSTRB_EN
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
`else
    unused_args = ^{old_val, strb};
    merged      = new_val;
`endif
    return merged;
  endfunction

  ad9643_axil_wr_ch #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wr_ch (
    .clock_axi (s_axi_aclk),
    .aresetn   (s_axi_aresetn),
    .awaddr    (s_axi.awaddr),
    .awvalid   (s_axi.awvalid),
    .awready   (s_axi.awready),
    .wdata     (s_axi.wdata),
    .wstrb     (s_axi.wstrb),
    .wvalid    (s_axi.wvalid),
    .wready    (s_axi.wready),
    .bresp     (s_axi.bresp),
    .bvalid    (s_axi.bvalid),
    .bready    (s_axi.bready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb)
  );

  // Software-visible images of the packed registers.
  always_comb begin
    ctrl_word                  = '0;
    ctrl_word[CTRL_CAPTURE_EN] = capture_en;
    ctrl_word[CTRL_TEST_MODE]  = test_mode;
    status_word                = {frame_cnt, 15'b0, ovf};
  end

  // Write decode. STATUS merges against zero so only strobed, written-one
  // bits clear the overflow flag.
  always_comb begin
    wr_sel = {wr_addr[3:2], 2'b00};
    case (wr_sel)
      OFF_CTRL:      wr_old = ctrl_word;
      OFF_FRAME_LEN: wr_old = {16'b0, frame_len};
      OFF_SCRATCH:   wr_old = scratch;
      default:       wr_old = '0;
    endcase
    wr_word  = merge_strb(wr_old, wr_data, wr_strb);
    soft_clr = wr_en && (wr_sel == OFF_CTRL) && wr_word[CTRL_SOFT_RST];
    ovf_w1c  = wr_en && (wr_sel == OFF_STATUS) && wr_word[0];
  end

  // Control registers and the soft reset pulse (high the cycle after commit).
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      capture_en <= 1'b0;
      test_mode  <= 1'b0;
      soft_rst   <= 1'b0;
      frame_len  <= FRAME_LEN_RST;
      scratch    <= '0;
    end else begin
      soft_rst <= soft_clr;
      if (wr_en) begin
        case (wr_sel)
          OFF_CTRL: begin
            capture_en <= wr_word[CTRL_CAPTURE_EN];
            test_mode  <= wr_word[CTRL_TEST_MODE];
          end
          OFF_FRAME_LEN: frame_len <= wr_word[15:0];
          OFF_SCRATCH:   scratch   <= wr_word;
          default: ;
        endcase
      end
    end
  end

  // Status: soft reset clears, a new overflow beats a simultaneous W1C.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      ovf       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (soft_clr)       ovf <= 1'b0;
      else if (ovf_pulse) ovf <= 1'b1;
      else if (ovf_w1c)   ovf <= 1'b0;

      if (soft_clr)         frame_cnt <= '0;
      else if (frame_pulse) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Read decode against current register contents (pre-write on collisions).
  always_comb begin
    rd_sel    = {s_axi.araddr[3:2], 2'b00};
    rd_mapped = (s_axi.araddr >> 4) == '0;
    case (rd_sel)
      OFF_CTRL:      rd_word = ctrl_word;
      OFF_FRAME_LEN: rd_word = {16'b0, frame_len};
      OFF_STATUS:    rd_word = status_word;
      OFF_SCRATCH:   rd_word = scratch;
      default:       rd_word = '0;
    endcase
  end

  // Read FSM: capture data on the AR handshake, hold it until R is taken.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rd_state  <= RD_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (s_axi.arvalid && arready_q) begin
            rd_state  <= RD_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_mapped ? rd_word : '0;
            rresp_q   <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
          end else begin
            arready_q <= 1'b1;
          end
        end
        RD_DATA: begin
          if (s_axi.rready) begin
            rd_state  <= RD_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_ad9643_axil_regs.sv
// Self-checking bench for ad9643_axil_regs (built with a 5-bit address so the
// unmapped window at 0x10..0x1C is reachable).
module tb_ad9643_axil_regs;
  import ad9643_regs_pkg::*;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ovf_pulse = 1'b0;
  logic        frame_pulse = 1'b0;
  logic        capture_en;
  logic        test_mode;
  logic        soft_rst;
  logic [15:0] frame_len;

  ad9643_axil_if #(.ADDR_WIDTH(AW)) bus ();

  ad9643_axil_regs #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(32),
    .FRAME_LEN_RST(16'd1024)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rstn),
    .s_axi         (bus),
    .capture_en    (capture_en),
    .test_mode     (test_mode),
    .soft_rst      (soft_rst),
    .frame_len     (frame_len),
    .ovf_pulse     (ovf_pulse),
    .frame_pulse   (frame_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct {
    bit          is_wr;
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [1:0]  resp;
  } vec_t;

  exp_t wq[$];
  exp_t rq[$];
  int   checks = 0;
  int   errors = 0;
  int   soft_cnt = 0;
  int   soft_bad = 0;

  // soft_rst must coincide with the first B cycle of the committing write
  always @(negedge clk) begin
    if (soft_rst === 1'b1) begin
      soft_cnt++;
      if (bus.bvalid !== 1'b1) soft_bad++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic write_gen(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input int aw_delay, input int w_delay, input int b_delay,
                           input string name);
    exp_t e;
    int   c;
    bit   aw_done, w_done, aw_fire, w_fire, early, stable;
    logic [1:0] r0;
    e.data = '0;
    e.resp = exp_resp;
    wq.push_back(e);
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    c = 0; aw_done = 0; w_done = 0; early = 0;
    while (!(aw_done && w_done) && c < 40) begin
      bus.awvalid = !aw_done && (c >= aw_delay);
      bus.wvalid  = !w_done && (c >= w_delay);
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      if (bus.bvalid === 1'b1) early = 1;
      @(posedge clk); #1;
      c++;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      timeout_fail({name, "_addr"});
      void'(wq.pop_back());
      return;
    end
    if (aw_delay != w_delay) check({name, "_b_early"}, 32'(early), 32'd0);
    c = 0;
    while (bus.bvalid !== 1'b1 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    if (bus.bvalid !== 1'b1) begin
      timeout_fail({name, "_b"});
      void'(wq.pop_back());
      return;
    end
    r0 = bus.bresp;
    stable = 1;
    for (int i = 0; i < b_delay; i++) begin
      @(posedge clk); #1;
      if (bus.bvalid !== 1'b1 || bus.bresp !== r0) stable = 0;
    end
    if (b_delay > 0) check({name, "_b_stable"}, 32'(stable), 32'd1);
    bus.bready = 1'b1;
    e = wq.pop_front();
    check({name, "_bresp"}, 32'(bus.bresp), 32'(e.resp));
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check({name, "_b_drop"}, 32'(bus.bvalid), 32'd0);
  endtask

  task automatic read_gen(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int r_delay, input string name);
    exp_t e;
    int   c;
    bit   fired, stable;
    logic [31:0] d0;
    e.data = exp_data;
    e.resp = exp_resp;
    rq.push_back(e);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    c = 0; fired = 0;
    while (!fired && c < 40) begin
      fired = bus.arready;
      @(posedge clk); #1;
      c++;
    end
    bus.arvalid = 1'b0;
    if (!fired) begin
      timeout_fail({name, "_ar"});
      void'(rq.pop_back());
      return;
    end
    c = 0;
    while (bus.rvalid !== 1'b1 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    if (bus.rvalid !== 1'b1) begin
      timeout_fail({name, "_r"});
      void'(rq.pop_back());
      return;
    end
    d0 = bus.rdata;
    stable = 1;
    for (int i = 0; i < r_delay; i++) begin
      @(posedge clk); #1;
      if (bus.rvalid !== 1'b1 || bus.rdata !== d0) stable = 0;
    end
    if (r_delay > 0) check({name, "_r_stable"}, 32'(stable), 32'd1);
    bus.rready = 1'b1;
    e = rq.pop_front();
    check({name, "_rdata"}, bus.rdata, e.data);
    check({name, "_rresp"}, 32'(bus.rresp), 32'(e.resp));
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic pulse(input bit is_frame);
    if (is_frame) frame_pulse = 1'b1; else ovf_pulse = 1'b1;
    @(posedge clk); #1;
    frame_pulse = 1'b0;
    ovf_pulse   = 1'b0;
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[14];
    logic [31:0] scr_exp;
    int          c;
    bit          fired, saw_b;

`ifdef AD9643_AXIL_WSTRB_EN
    scr_exp = 32'hFF34FF78;
`else
    scr_exp = 32'h12345678;
`endif
    tbl[0]  = '{1'b0, 5'h04, 32'h0,        4'h0, 32'h0000_0400, RESP_OKAY};
    tbl[1]  = '{1'b1, 5'h00, 32'h0123_4561, 4'hF, 32'h0,         RESP_OKAY};
    tbl[2]  = '{1'b0, 5'h00, 32'h0,        4'h0, 32'h0000_0001, RESP_OKAY};
    tbl[3]  = '{1'b1, 5'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0,         RESP_OKAY};
    tbl[4]  = '{1'b1, 5'h0C, 32'h1234_5678, 4'h5, 32'h0,         RESP_OKAY};
    tbl[5]  = '{1'b0, 5'h0C, 32'h0,        4'h0, scr_exp,       RESP_OKAY};
    tbl[6]  = '{1'b1, 5'h10, 32'hDEAD_BEEF, 4'hF, 32'h0,         RESP_SLVERR};
    tbl[7]  = '{1'b0, 5'h10, 32'h0,        4'h0, 32'h0,         RESP_SLVERR};
    tbl[8]  = '{1'b0, 5'h0C, 32'h0,        4'h0, scr_exp,       RESP_OKAY};
    tbl[9]  = '{1'b0, 5'h00, 32'h0,        4'h0, 32'h0000_0001, RESP_OKAY};
    tbl[10] = '{1'b0, 5'h04, 32'h0,        4'h0, 32'h0000_0400, RESP_OKAY};
    tbl[11] = '{1'b0, 5'h08, 32'h0,        4'h0, 32'h0,         RESP_OKAY};
    tbl[12] = '{1'b1, 5'h18, 32'h0000_FFFF, 4'hF, 32'h0,         RESP_SLVERR};
    tbl[13] = '{1'b0, 5'h1C, 32'h0,        4'h0, 32'h0,         RESP_SLVERR};

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_handshake", 32'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}), 32'd0);
    check("rst_resp", 32'({bus.bresp, bus.rresp}), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_ctrl", 32'({capture_en, test_mode, soft_rst}), 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'h400);
    rstn = 1'b1;
    @(posedge clk); #1;

    // table-driven single transactions
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].is_wr)
        write_gen(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp, 0, 0, 0, $sformatf("vec%0d", i));
      else
        read_gen(tbl[i].addr, tbl[i].exp, tbl[i].resp, 0, $sformatf("vec%0d", i));
    end
    check("ctrl_capture_en", 32'(capture_en), 32'd1);
    check("ctrl_test_mode", 32'(test_mode), 32'd0);
    check("frame_len_unchanged", 32'(frame_len), 32'h400);
    check("soft_rst_quiet", 32'(soft_cnt), 32'd0);

    // W leads AW by three cycles
    write_gen(5'h04, 32'h89AB_CDE2, 4'hF, RESP_OKAY, 3, 0, 0, "w_first");
    check("frame_len_out", 32'(frame_len), 32'hCDE2);
    read_gen(5'h04, 32'h0000_CDE2, RESP_OKAY, 3, "rd_frame_len");

    // AW leads W
    write_gen(5'h00, 32'h0000_0005, 4'hF, RESP_OKAY, 0, 2, 0, "aw_first");
    check("test_mode_set", 32'({capture_en, test_mode}), 32'd3);
    read_gen(5'h00, 32'h0000_0005, RESP_OKAY, 0, "rd_ctrl5");

    // B held while bready stays low
    write_gen(5'h0C, 32'hA5A5_A5A5, 4'hF, RESP_OKAY, 0, 0, 5, "b_hold");

    // read and write to the same register in the same cycle
    fork
      write_gen(5'h0C, 32'h5A5A_0000, 4'hF, RESP_OKAY, 0, 0, 0, "coll_wr");
      read_gen(5'h0C, 32'hA5A5_A5A5, RESP_OKAY, 0, "coll_rd");
    join
    read_gen(5'h0C, 32'h5A5A_0000, RESP_OKAY, 0, "after_coll");

    // status: frame counter, sticky overflow, W1C vs new overflow
    pulse(1'b1);
    pulse(1'b1);
    pulse(1'b0);
    read_gen(5'h08, 32'h0002_0001, RESP_OKAY, 0, "status_a");
    fork
      write_gen(5'h08, 32'h0000_0001, 4'hF, RESP_OKAY, 0, 0, 0, "w1c_vs_ovf");
      begin
        ovf_pulse = 1'b1;
        @(posedge clk); #1;
        ovf_pulse = 1'b0;
      end
    join
    read_gen(5'h08, 32'h0002_0001, RESP_OKAY, 0, "status_b");
    write_gen(5'h08, 32'hFFFF_0001, 4'hF, RESP_OKAY, 0, 0, 0, "w1c");
    read_gen(5'h08, 32'h0002_0000, RESP_OKAY, 0, "status_c");

    // soft reset pulse clears status
    pulse(1'b0);
    soft_cnt = 0;
    soft_bad = 0;
    write_gen(5'h00, 32'h0000_0002, 4'hF, RESP_OKAY, 0, 0, 0, "soft_rst");
    check("soft_rst_count", 32'(soft_cnt), 32'd1);
    check("soft_rst_align", 32'(soft_bad), 32'd0);
    read_gen(5'h08, 32'h0, RESP_OKAY, 0, "status_after_soft");
    read_gen(5'h00, 32'h0, RESP_OKAY, 0, "ctrl_after_soft");

    // frame counter wrap
    frame_pulse = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    frame_pulse = 1'b0;
    read_gen(5'h08, 32'hFFFF_0000, RESP_OKAY, 0, "cnt_max");
    pulse(1'b1);
    read_gen(5'h08, 32'h0, RESP_OKAY, 0, "cnt_wrap");

    // reset with an R pending and an AW latched
    bus.araddr  = 5'h04;
    bus.awaddr  = 5'h0C;
    bus.arvalid = 1'b1;
    bus.awvalid = 1'b1;
    c = 0; fired = 0;
    while (!fired && c < 20) begin
      fired = bus.arready && bus.awready;
      @(posedge clk); #1;
      c++;
    end
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b0;
    if (!fired) timeout_fail("abort_setup");
    check("abort_rvalid_pending", 32'(bus.rvalid), 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("abort_rvalid", 32'(bus.rvalid), 32'd0);
    check("abort_ready", 32'({bus.arready, bus.awready, bus.wready, bus.bvalid}), 32'd0);
    rstn = 1'b1;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    saw_b = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.bvalid === 1'b1 || bus.rvalid === 1'b1) saw_b = 1;
    end
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    check("abort_no_resp", 32'(saw_b), 32'd0);
    read_gen(5'h04, 32'h0000_0400, RESP_OKAY, 0, "post_rst_len");
    read_gen(5'h0C, 32'h0, RESP_OKAY, 0, "post_rst_scratch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
